// File: rtl/data_memory_stage.sv
// MEM-stage data memory: big-endian byte/half/word loads and stores with
// alignment checking and a sticky first-fault record.
module data_memory_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic        fault,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic             r_fault;
  logic [31:0]      r_fault_addr;

  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_word;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_wmask;
  logic [31:0]      w_wdata;
  logic             w_access;
  logic             w_store;

  assign w_idx    = addr[IDX_W+1:2];
  assign w_word   = r_mem[w_idx];
  assign w_access = mem_read | mem_write;
  assign w_store  = mem_write & ~misaligned;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    misaligned = 1'b0;
    if (w_access) begin
      case (size)
        SZ_HALF: misaligned = addr[0];
        SZ_WORD: misaligned = |addr[1:0];
        SZ_ILL:  misaligned = 1'b1;
        default: misaligned = 1'b0;
      endcase
    end
  end

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    w_byte = w_word[7:0];
    case (addr[1:0])
      2'd0: w_byte = w_word[31:24];
      2'd1: w_byte = w_word[23:16];
      2'd2: w_byte = w_word[15:8];
      default: w_byte = w_word[7:0];
    endcase
    w_half = addr[1] ? w_word[15:0] : w_word[31:16];
  end

  always_comb begin
    read_data = '0;
    if (mem_read && !misaligned) begin
      case (size)
        SZ_BYTE: read_data = {{24{w_byte[7] & ~load_unsigned}}, w_byte};
        SZ_HALF: read_data = {{16{w_half[15] & ~load_unsigned}}, w_half};
        SZ_WORD: read_data = w_word;
        default: read_data = '0;
      endcase
    end
  end

  always_comb begin
    w_wmask = '0;
    w_wdata = '0;
    case (size)
      SZ_BYTE: begin
        w_wdata = {4{write_data[7:0]}};
        case (addr[1:0])
          2'd0: w_wmask = 32'hFF00_0000;
          2'd1: w_wmask = 32'h00FF_0000;
          2'd2: w_wmask = 32'h0000_FF00;
          default: w_wmask = 32'h0000_00FF;
        endcase
      end
      SZ_HALF: begin
        w_wdata = {2{write_data[15:0]}};
        w_wmask = addr[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
      end
      SZ_WORD: begin
        w_wdata = write_data;
        w_wmask = 32'hFFFF_FFFF;
      end
      default: begin
        w_wdata = '0;
        w_wmask = '0;
      end
    endcase
  end

  // NOTE: the array is cleared on reset because the debug flow expects a known-zero memory; most RAMs are not reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
    end else if (w_store) begin
      r_mem[w_idx] <= (w_word & ~w_wmask) | (w_wdata & w_wmask);
    end
  end

  // First fault wins; only reset clears the record.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else if (misaligned && !r_fault) begin
      r_fault      <= 1'b1;
      r_fault_addr <= addr;
    end
  end

  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;

endmodule

// File: tb/tb_data_memory_stage.sv
// Scoreboard bench for data_memory_stage: each vector pushes its expected
// outputs, inputs are driven after posedge, outputs are sampled at negedge.
module tb_data_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        misaligned;
  logic        fault;
  logic [31:0] fault_addr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] e_rd;
    logic        e_mis;
    logic        e_f;
    logic [31:0] e_fa;
  } vec_t;

  vec_t sb[$];

  data_memory_stage #(.DEPTH_WORDS(256), .IDX_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .size          (size),
    .load_unsigned (load_unsigned),
    .addr          (addr),
    .write_data    (write_data),
    .read_data     (read_data),
    .misaligned    (misaligned),
    .fault         (fault),
    .fault_addr    (fault_addr)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic rst_n, input logic rd,
                              input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] e_rd, input logic e_mis,
                              input logic e_f, input logic [31:0] e_fa);
    vec_t v;
    v.name = name; v.rst_n = rst_n; v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns;
    v.a = a; v.wd = wd; v.e_rd = e_rd; v.e_mis = e_mis; v.e_f = e_f; v.e_fa = e_fa;
    return v;
  endfunction

  // Drive one vector, record its expectation, and move to the sampling point.
  task automatic drive(input vec_t v);
    sb.push_back(v);
    reset = v.rst_n; mem_read = v.rd; mem_write = v.wr; size = v.sz;
    load_unsigned = v.uns; addr = v.a; write_data = v.wd;
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t vs[$];
    vec_t e;
    vs.push_back(mk("rst_idle",       0, 0, 0, 2'b00, 0, 32'h0,  32'h0, 32'h0, 0, 0, 32'h0));
    vs.push_back(mk("rst_sz11_noacc", 0, 0, 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 0, 0, 32'h0));
    foreach (vs[i]) begin
      drive(vs[i]);
      e = sb.pop_front();
      checks += 4;
      if (read_data !== e.e_rd) begin errors++; $display("FAIL %s read_data got %h exp %h", e.name, read_data, e.e_rd); end
      if (misaligned !== e.e_mis) begin errors++; $display("FAIL %s misaligned got %b exp %b", e.name, misaligned, e.e_mis); end
      if (fault !== e.e_f) begin errors++; $display("FAIL %s fault got %b exp %b", e.name, fault, e.e_f); end
      if (fault_addr !== e.e_fa) begin errors++; $display("FAIL %s fault_addr got %h exp %h", e.name, fault_addr, e.e_fa); end
      next_cycle();
    end
  endtask

  task automatic test_word_and_subword();
    vec_t vs[$];
    vec_t e;
    vs.push_back(mk("sw_10",   1, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0, 32'h0));
    vs.push_back(mk("lw_10",   1, 1, 0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0));
    vs.push_back(mk("lb_11",   1, 1, 0, 2'b00, 0, 32'h11, 32'h0,        32'hFFFFFFAD, 0, 0, 32'h0));
    vs.push_back(mk("lbu_11",  1, 1, 0, 2'b00, 1, 32'h11, 32'h0,        32'h000000AD, 0, 0, 32'h0));
    vs.push_back(mk("lh_12",   1, 1, 0, 2'b01, 0, 32'h12, 32'h0,        32'hFFFFBEEF, 0, 0, 32'h0));
    vs.push_back(mk("lhu_10",  1, 1, 0, 2'b01, 1, 32'h10, 32'h0,        32'h0000DEAD, 0, 0, 32'h0));
    vs.push_back(mk("lh_10",   1, 1, 0, 2'b01, 0, 32'h10, 32'h0,        32'hFFFFDEAD, 0, 0, 32'h0));
    vs.push_back(mk("lb_10",   1, 1, 0, 2'b00, 0, 32'h10, 32'h0,        32'hFFFFFFDE, 0, 0, 32'h0));
    vs.push_back(mk("lbu_13",  1, 1, 0, 2'b00, 1, 32'h13, 32'h0,        32'h000000EF, 0, 0, 32'h0));
    vs.push_back(mk("sb_13",   1, 0, 1, 2'b00, 0, 32'h13, 32'hFFFFFF55, 32'h0,        0, 0, 32'h0));
    vs.push_back(mk("lw_sb",   1, 1, 0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBE55, 0, 0, 32'h0));
    vs.push_back(mk("sh_10",   1, 0, 1, 2'b01, 0, 32'h10, 32'hABCD1234, 32'h0,        0, 0, 32'h0));
    vs.push_back(mk("lw_sh",   1, 1, 0, 2'b10, 0, 32'h10, 32'h0,        32'h1234BE55, 0, 0, 32'h0));
    vs.push_back(mk("sb_11",   1, 0, 1, 2'b00, 0, 32'h11, 32'h00000077, 32'h0,        0, 0, 32'h0));
    vs.push_back(mk("sh_12",   1, 0, 1, 2'b01, 0, 32'h12, 32'h0000CAFE, 32'h0,        0, 0, 32'h0));
    vs.push_back(mk("lw_mix",  1, 1, 0, 2'b10, 0, 32'h10, 32'h0,        32'h1277CAFE, 0, 0, 32'h0));
    foreach (vs[i]) begin
      drive(vs[i]);
      e = sb.pop_front();
      checks += 4;
      if (read_data !== e.e_rd) begin errors++; $display("FAIL %s read_data got %h exp %h", e.name, read_data, e.e_rd); end
      if (misaligned !== e.e_mis) begin errors++; $display("FAIL %s misaligned got %b exp %b", e.name, misaligned, e.e_mis); end
      if (fault !== e.e_f) begin errors++; $display("FAIL %s fault got %b exp %b", e.name, fault, e.e_f); end
      if (fault_addr !== e.e_fa) begin errors++; $display("FAIL %s fault_addr got %h exp %h", e.name, fault_addr, e.e_fa); end
      next_cycle();
    end
  endtask

  task automatic test_misaligned();
    vec_t vs[$];
    vec_t e;
    vs.push_back(mk("sw_22_bad",  1, 0, 1, 2'b10, 0, 32'h22, 32'h99999999, 32'h0,        1, 0, 32'h0));
    vs.push_back(mk("lw_20_same", 1, 1, 0, 2'b10, 0, 32'h20, 32'h0,        32'h0,        0, 1, 32'h22));
    vs.push_back(mk("lh_31_bad",  1, 1, 0, 2'b01, 0, 32'h31, 32'h0,        32'h0,        1, 1, 32'h22));
    vs.push_back(mk("ld_sz11",    1, 1, 0, 2'b11, 0, 32'h10, 32'h0,        32'h0,        1, 1, 32'h22));
    vs.push_back(mk("lw_12_bad",  1, 1, 0, 2'b10, 0, 32'h12, 32'h0,        32'h0,        1, 1, 32'h22));
    vs.push_back(mk("st_sz11",    1, 0, 1, 2'b11, 0, 32'h10, 32'h0,        32'h0,        1, 1, 32'h22));
    vs.push_back(mk("sh_13_bad",  1, 0, 1, 2'b01, 0, 32'h13, 32'h0,        32'h0,        1, 1, 32'h22));
    vs.push_back(mk("lw_10_kept", 1, 1, 0, 2'b10, 0, 32'h10, 32'h0,        32'h1277CAFE, 0, 1, 32'h22));
    foreach (vs[i]) begin
      drive(vs[i]);
      e = sb.pop_front();
      checks += 4;
      if (read_data !== e.e_rd) begin errors++; $display("FAIL %s read_data got %h exp %h", e.name, read_data, e.e_rd); end
      if (misaligned !== e.e_mis) begin errors++; $display("FAIL %s misaligned got %b exp %b", e.name, misaligned, e.e_mis); end
      if (fault !== e.e_f) begin errors++; $display("FAIL %s fault got %b exp %b", e.name, fault, e.e_f); end
      if (fault_addr !== e.e_fa) begin errors++; $display("FAIL %s fault_addr got %h exp %h", e.name, fault_addr, e.e_fa); end
      next_cycle();
    end
  endtask

  task automatic test_alias_same_cycle();
    vec_t vs[$];
    vec_t e;
    vs.push_back(mk("sw_400",     1, 0, 1, 2'b10, 0, 32'h400,      32'hA5A5A5A5, 32'h0,        0, 1, 32'h22));
    vs.push_back(mk("lw_000",     1, 1, 0, 2'b10, 0, 32'h0,        32'h0,        32'hA5A5A5A5, 0, 1, 32'h22));
    vs.push_back(mk("lw_alias10", 1, 1, 0, 2'b10, 0, 32'hFFFFFC10, 32'h0,        32'h1277CAFE, 0, 1, 32'h22));
    vs.push_back(mk("rw_20_old",  1, 1, 1, 2'b10, 0, 32'h20,       32'h00000001, 32'h0,        0, 1, 32'h22));
    vs.push_back(mk("lw_20_new",  1, 1, 0, 2'b10, 0, 32'h20,       32'h0,        32'h00000001, 0, 1, 32'h22));
    foreach (vs[i]) begin
      drive(vs[i]);
      e = sb.pop_front();
      checks += 4;
      if (read_data !== e.e_rd) begin errors++; $display("FAIL %s read_data got %h exp %h", e.name, read_data, e.e_rd); end
      if (misaligned !== e.e_mis) begin errors++; $display("FAIL %s misaligned got %b exp %b", e.name, misaligned, e.e_mis); end
      if (fault !== e.e_f) begin errors++; $display("FAIL %s fault got %b exp %b", e.name, fault, e.e_f); end
      if (fault_addr !== e.e_fa) begin errors++; $display("FAIL %s fault_addr got %h exp %h", e.name, fault_addr, e.e_fa); end
      next_cycle();
    end
  endtask

  task automatic test_reset_during_store();
    vec_t vs[$];
    vec_t e;
    vs.push_back(mk("rst_sw_10", 0, 0, 1, 2'b10, 0, 32'h10, 32'hFFFFFFFF, 32'h0, 0, 1, 32'h22));
    vs.push_back(mk("post_10",   1, 1, 0, 2'b10, 0, 32'h10, 32'h0,        32'h0, 0, 0, 32'h0));
    vs.push_back(mk("post_00",   1, 1, 0, 2'b10, 0, 32'h0,  32'h0,        32'h0, 0, 0, 32'h0));
    vs.push_back(mk("post_20",   1, 1, 0, 2'b10, 0, 32'h20, 32'h0,        32'h0, 0, 0, 32'h0));
    foreach (vs[i]) begin
      drive(vs[i]);
      e = sb.pop_front();
      checks += 4;
      if (read_data !== e.e_rd) begin errors++; $display("FAIL %s read_data got %h exp %h", e.name, read_data, e.e_rd); end
      if (misaligned !== e.e_mis) begin errors++; $display("FAIL %s misaligned got %b exp %b", e.name, misaligned, e.e_mis); end
      if (fault !== e.e_f) begin errors++; $display("FAIL %s fault got %b exp %b", e.name, fault, e.e_f); end
      if (fault_addr !== e.e_fa) begin errors++; $display("FAIL %s fault_addr got %h exp %h", e.name, fault_addr, e.e_fa); end
      next_cycle();
    end
  endtask

  initial begin
    reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'b00;
    load_unsigned = 1'b0; addr = '0; write_data = '0;
    next_cycle();
    test_reset();
    test_word_and_subword();
    test_misaligned();
    test_alias_same_cycle();
    test_reset_during_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_stage.md
Name: data_memory_stage

Overview:
MEM-stage data memory for the 5-stage MIPS datapath. It sits between the EX/MEM register and the MEM/WB register and produces the Read_data that MEM/WB captures.
- Big-endian word array with byte/half/word loads and stores.
- Load sign/zero extension.
- Alignment checking, with a sticky fault record for debug.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; power of two, >= 4
IDX_W, 8, word-index width; must equal log2(DEPTH_WORDS)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (sampled on rising clk edge; 0 = reset)
mem_read  input  1  load request this cycle
mem_write  input  1  store request this cycle
size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal
load_unsigned  input  1  1 = zero-extend sub-word loads (lbu/lhu), 0 = sign-extend (lb/lh)
addr  input  32  byte address (ALU result from EX/MEM)
write_data  input  32  store data; sub-word stores use low bits
read_data  output  32  combinational load result, feeds MEM/WB Read_data_in
misaligned  output  1  combinational: current access is illegal
fault  output  1  registered sticky fault flag
fault_addr  output  32  registered address of the first faulting access

Behaviour:
- Storage: DEPTH_WORDS x 32 array.
  - Word index = addr[IDX_W+1:2]; addr[31:IDX_W+2] are ignored, so addresses alias.
- Byte lanes are big-endian:
  - offset 0 -> bits[31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - Halfword offset 0 -> [31:16], offset 2 -> [15:0].
- Illegal access: (mem_read | mem_write) and any of:
  - size == 11
  - size == 01 with addr[0] == 1
  - size == 10 with addr[1:0] != 00
- misaligned = the illegal condition above; 0 when neither mem_read nor mem_write is asserted.
- Reads (combinational, zero added latency):
  - mem_read = 0 or misaligned = 1 -> read_data = 0.
  - Word load -> the whole word.
  - Byte/half load -> the selected lane; bits above it filled with the lane MSB (load_unsigned = 0) or 0 (load_unsigned = 1).
- Writes (synchronous, on rising clk):
  - Happen only when reset = 1, mem_write = 1 and misaligned = 0.
  - Only the addressed lanes are updated: byte writes write_data[7:0], half writes write_data[15:0], word writes write_data.
  - Other lanes hold their value.
- Same-cycle read and write to the same word: read_data shows pre-write contents. New data is visible from the next cycle.
- Fault record (registered):
  - On a rising edge with reset = 1 and misaligned = 1: if fault == 0, set fault = 1 and fault_addr = addr.
  - If fault == 1 already, both hold; the first fault wins.
  - Cleared only by reset.
- Reset (reset = 0 at rising edge):
  - All memory words, fault and fault_addr go to 0.
  - Any store in that cycle is dropped; reset has priority.
  - A reset asserted in the middle of a store sequence leaves no partial state.
- Reset values of outputs:
  - fault = 0, fault_addr = 0.
  - read_data = 0, misaligned = 0 while mem_read/mem_write are low.
- Misaligned stores never modify memory. Misaligned loads return 0.

Test Plan:
1. Reset, then word store: addr 0x10, data 0xDEADBEEF, size 10. Next cycle word load at 0x10 -> read_data 0xDEADBEEF, misaligned 0, fault 0.
2. Sub-word loads from the word at 0x10:
   - lb at 0x11 -> 0xFFFFFFAD.
   - lbu at 0x11 -> 0x000000AD.
   - lh at 0x12 -> 0xFFFFBEEF.
   - lhu at 0x10 -> 0x0000DEAD.
3. Sub-word stores, read back as word at 0x10:
   - sb 0x55 at 0x13 -> 0xDEADBE55.
   - then sh 0x1234 at 0x10 -> 0x1234BE55.
4. Misaligned and illegal accesses:
   - sw to 0x22 -> misaligned 1, memory unchanged, fault 1, fault_addr 0x22.
   - then lh at 0x31 -> fault_addr stays 0x22.
   - size 11 load -> read_data 0.
5. Aliasing and same-cycle read/write:
   - Store 0xA5A5A5A5 at 0x400 (DEPTH 256) -> word load at 0x000 returns 0xA5A5A5A5.
   - Simultaneous load+store at 0x20 (old 0x0, new 0x1) -> read_data 0 that cycle, 0x1 next cycle.
6. Reset during a store cycle with a pending fault: memory, fault and fault_addr all go to 0, and the store does not land.
